// File: rtl/mem_line_arbiter_if.sv
// Bundle of the d_cache, i_cache and main-memory signals around the line arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the
// surrounding environment: both caches plus the memory.
interface mem_line_arbiter_if #(
  parameter int WORD_SIZE = 16
);
  localparam int LINE = 4 * WORD_SIZE;

  logic            d_read;
  logic            d_write;
  logic [15:0]     d_addr;
  logic [LINE-1:0] d_wdata;
  logic [LINE-1:0] d_rdata;
  logic            d_ready;

  logic            i_read;
  logic [15:0]     i_addr;
  logic [LINE-1:0] i_rdata;
  logic            i_ready;

  logic            mem_read;
  logic            mem_write;
  logic [15:0]     mem_addr;
  logic [LINE-1:0] mem_wdata;
  logic [LINE-1:0] mem_rdata;

  modport master (
    output d_read, d_write, d_addr, d_wdata,
    input  d_rdata, d_ready,
    output i_read, i_addr,
    input  i_rdata, i_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  d_read, d_write, d_addr, d_wdata,
    output d_rdata, d_ready,
    input  i_read, i_addr,
    output i_rdata, i_ready,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/mem_line_arbiter.sv
// Round-robin arbiter between d_cache and i_cache for whole-line transfers on a
// single-ported, fixed-latency main memory.
// A transfer runs in three phases:
//  - IDLE samples the requests and latches the winner.
//  - XFER holds the memory strobes for LATENCY cycles.
//  - DONE pulses the winner's ready for one cycle.
module mem_line_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int LATENCY   = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_line_arbiter_if.slave bus
);
  localparam int LINE = 4 * WORD_SIZE;
  // Counter must reach LATENCY without wrapping; never narrower than 3 bits.
  localparam int CW = ($clog2(LATENCY + 1) < 3) ? 3 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [CW-1:0]   cnt_reg;
  logic            last_d_reg;   // 1: D had the last grant, 0: I had it
  logic            gnt_d_reg;    // port owning the current transfer
  logic            op_write_reg;
  logic [15:0]     addr_reg;
  logic [LINE-1:0] wdata_reg;

  logic [WORD_SIZE-1:0] d_word_reg [4];
  logic [WORD_SIZE-1:0] i_word_reg [4];
  logic [LINE-1:0]      d_line;
  logic [LINE-1:0]      i_line;

  logic d_pend;
  logic i_pend;
  logic any_pend;
  logic pick_d;
  logic last_cycle;
  logic capture_d;
  logic capture_i;

  // Word address bits [1:0] select a word inside the line and play no part here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.d_addr[1:0], bus.i_addr[1:0]};

  // Request decode and the round-robin choice. A simultaneous read and write
  // from D counts as a write.
  always_comb begin
    d_pend     = bus.d_read | bus.d_write;
    i_pend     = bus.i_read;
    any_pend   = d_pend | i_pend;
    pick_d     = d_pend & (~i_pend | ~last_d_reg);
    last_cycle = (state_reg == XFER) && (cnt_reg == CW'(LATENCY));
    capture_d  = last_cycle & ~op_write_reg & gnt_d_reg;
    capture_i  = last_cycle & ~op_write_reg & ~gnt_d_reg;
  end

  // State register. A reset aborts any transfer in flight at that edge.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_pend) state_next = XFER;
      XFER:    if (cnt_reg == CW'(LATENCY)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the winning request and count the strobe cycles.
  // Requester inputs are ignored until the next IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg      <= '0;
      last_d_reg   <= 1'b0;
      gnt_d_reg    <= 1'b0;
      op_write_reg <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_pend) begin
            gnt_d_reg    <= pick_d;
            last_d_reg   <= pick_d;
            op_write_reg <= pick_d & bus.d_write;
            addr_reg     <= pick_d ? {bus.d_addr[15:2], 2'b00} : {bus.i_addr[15:2], 2'b00};
            wdata_reg    <= pick_d ? bus.d_wdata : '0;
            cnt_reg      <= CW'(1);
          end
        end
        XFER: begin
          if (cnt_reg == CW'(LATENCY)) cnt_reg <= '0;
          else                         cnt_reg <= cnt_reg + CW'(1);
        end
        default: cnt_reg <= '0;
      endcase
    end
  end

  // Per-word fill registers. Word 0 sits in the top slice of the line.
  for (genvar gi = 0; gi < 4; gi++) begin : g_word
    // Capture this word of the memory line into the granted port on the last strobe cycle of a read.
    always_ff @(posedge clk) begin
      if (reset) begin
        d_word_reg[gi] <= '0;
        i_word_reg[gi] <= '0;
      end else begin
        if (capture_d) d_word_reg[gi] <= bus.mem_rdata[LINE-1-gi*WORD_SIZE -: WORD_SIZE];
        if (capture_i) i_word_reg[gi] <= bus.mem_rdata[LINE-1-gi*WORD_SIZE -: WORD_SIZE];
      end
    end
    assign d_line[LINE-1-gi*WORD_SIZE -: WORD_SIZE] = d_word_reg[gi];
    assign i_line[LINE-1-gi*WORD_SIZE -: WORD_SIZE] = i_word_reg[gi];
  end

  // Outputs. Strobes are driven only in XFER and ready only in DONE.
  // Address and write data come straight from the latched copy.
  always_comb begin
    bus.mem_read  = (state_reg == XFER) & ~op_write_reg;
    bus.mem_write = (state_reg == XFER) & op_write_reg;
    bus.mem_addr  = addr_reg;
    bus.mem_wdata = wdata_reg;
    bus.d_ready   = (state_reg == DONE) & gnt_d_reg;
    bus.i_ready   = (state_reg == DONE) & ~gnt_d_reg;
    bus.d_rdata   = d_line;
    bus.i_rdata   = i_line;
  end
endmodule

// File: tb/tb_mem_line_arbiter.sv
// Directed bench for mem_line_arbiter.
// Expected transfers are queued when a request is raised and checked when the
// matching ready pulse appears. A second instance is built with LATENCY=1.
module tb_mem_line_arbiter;
  localparam int WS  = 16;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_line_arbiter_if #(.WORD_SIZE(WS)) bus ();
  mem_line_arbiter_if #(.WORD_SIZE(WS)) bus1 ();

  mem_line_arbiter #(.WORD_SIZE(WS), .LATENCY(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));
  mem_line_arbiter #(.WORD_SIZE(WS), .LATENCY(1))   dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // Memory model: fixed content per address, valid only in the last strobe cycle.
  function automatic logic [63:0] line_of(input logic [15:0] a);
    if (a == 16'h0010) return 64'h1111_2222_3333_4444;
    return {a, ~a, a ^ 16'h5A5A, a + 16'h1357};
  endfunction

  int run0 = 0;
  int run1 = 0;
  always @(posedge clk) begin
    run0 <= bus.mem_read ? run0 + 1 : 0;
    run1 <= bus1.mem_read ? run1 + 1 : 0;
  end
  assign bus.mem_rdata  = (bus.mem_read && run0 == LAT - 1) ? line_of(bus.mem_addr) : 64'hDEAD_BEEF_DEAD_BEEF;
  assign bus1.mem_rdata = (bus1.mem_read && run1 == 0) ? line_of(bus1.mem_addr) : 64'hDEAD_BEEF_DEAD_BEEF;

  typedef struct {
    bit          is_d;
    bit          is_wr;
    logic [15:0] addr;
    logic [63:0] data;
    int          rdy_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] mdl_d_rdata = '0;
  logic [63:0] mdl_i_rdata = '0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          c0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit is_d, input bit is_wr, input logic [15:0] addr,
                      input logic [63:0] data, input int rdy_cyc);
    exp_t e;
    e.is_d = is_d; e.is_wr = is_wr; e.addr = addr; e.data = data; e.rdy_cyc = rdy_cyc;
    sb.push_back(e);
  endtask

  // Run until the next ready pulse, then compare that transfer with the queue head.
  // If chg_cyc is reached, d_addr is moved to chg_addr mid-transfer.
  task automatic serve(input string tag, input int chg_cyc, input logic [15:0] chg_addr);
    exp_t        e;
    int          rd = 0;
    int          wr = 0;
    bit          got = 0;
    bit          both = 0;
    bit          multi = 0;
    bit          moved = 0;
    logic [15:0] a0 = '0;
    logic [63:0] w0 = '0;
    for (int k = 0; k < 40 && !got; k++) begin
      step();
      if (cyc == chg_cyc) bus.d_addr = chg_addr;
      if (bus.mem_read || bus.mem_write) begin
        if (rd + wr == 0) begin
          a0 = bus.mem_addr;
          w0 = bus.mem_wdata;
        end else if (bus.mem_addr !== a0 || bus.mem_wdata !== w0) begin
          moved = 1;
        end
        rd += int'(bus.mem_read);
        wr += int'(bus.mem_write);
        if (bus.mem_read && bus.mem_write) both = 1;
      end
      if (bus.d_ready && bus.i_ready) multi = 1;
      if (bus.d_ready || bus.i_ready) got = 1;
    end
    chk({tag, "_ready_seen"}, 64'(got), 64'd1);
    chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_ready_cycle"}, 64'(cyc), 64'(e.rdy_cyc));
      chk({tag, "_d_ready"}, 64'(bus.d_ready), 64'(e.is_d));
      chk({tag, "_i_ready"}, 64'(bus.i_ready), 64'(!e.is_d));
      chk({tag, "_rd_cycles"}, 64'(rd), e.is_wr ? 64'd0 : 64'(LAT));
      chk({tag, "_wr_cycles"}, 64'(wr), e.is_wr ? 64'(LAT) : 64'd0);
      chk({tag, "_mem_addr"}, 64'(a0), 64'(e.addr));
      if (e.is_wr) chk({tag, "_mem_wdata"}, w0, e.data);
      if (!e.is_wr) begin
        if (e.is_d) mdl_d_rdata = e.data;
        else        mdl_i_rdata = e.data;
      end
      chk({tag, "_strobes_both"}, 64'(both), 64'd0);
      chk({tag, "_multi_ready"}, 64'(multi), 64'd0);
      chk({tag, "_addr_stable"}, 64'(moved), 64'd0);
      chk({tag, "_d_rdata"}, bus.d_rdata, mdl_d_rdata);
      chk({tag, "_i_rdata"}, bus.i_rdata, mdl_i_rdata);
    end
    step();
    chk({tag, "_ready_pulse_end"}, 64'({bus.d_ready, bus.i_ready}), 64'd0);
    chk({tag, "_idle_strobes"}, 64'({bus.mem_read, bus.mem_write}), 64'd0);
    $display("xfer %s done at cycle %0d", tag, cyc);
  endtask

  initial begin
    bus.d_read = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.i_read = 0; bus.i_addr = '0;
    bus1.d_read = 0; bus1.d_write = 0; bus1.d_addr = '0; bus1.d_wdata = '0;
    bus1.i_read = 0; bus1.i_addr = '0;

    // Reset state.
    reset = 1;
    step(); step(); step();
    chk("rst_readys", 64'({bus.d_ready, bus.i_ready}), 64'd0);
    chk("rst_strobes", 64'({bus.mem_read, bus.mem_write}), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 64'd0);
    chk("rst_rdata", bus.d_rdata | bus.i_rdata, 64'd0);
    chk("rst_state", 64'(dut.state_reg), 64'd0);
    reset = 0;

    // I-read.
    c0 = cyc;
    bus.i_read = 1; bus.i_addr = 16'h0012;
    push(0, 0, 16'h0010, 64'h1111_2222_3333_4444, c0 + LAT + 1);
    serve("iread", -1, 16'h0);
    bus.i_read = 0;

    // D-write.
    c0 = cyc;
    bus.d_write = 1; bus.d_addr = 16'h0043; bus.d_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
    push(1, 1, 16'h0040, 64'hAAAA_BBBB_CCCC_DDDD, c0 + LAT + 1);
    serve("dwrite", -1, 16'h0);
    bus.d_write = 0;

    // Contention from reset: D first, then alternation while both stay requested.
    reset = 1;
    step(); step();
    mdl_d_rdata = '0; mdl_i_rdata = '0;
    reset = 0;
    c0 = cyc;
    bus.d_read = 1; bus.d_addr = 16'h0100;
    bus.i_read = 1; bus.i_addr = 16'h0200;
    push(1, 0, 16'h0100, line_of(16'h0100), c0 + 5);
    push(0, 0, 16'h0200, line_of(16'h0200), c0 + 11);
    push(1, 0, 16'h0300, line_of(16'h0300), c0 + 17);
    push(0, 0, 16'h0400, line_of(16'h0400), c0 + 23);
    serve("tie_d1", -1, 16'h0);
    bus.d_addr = 16'h0300;
    serve("tie_i1", -1, 16'h0);
    bus.i_addr = 16'h0400;
    serve("tie_d2", -1, 16'h0);
    serve("tie_i2", -1, 16'h0);
    bus.d_read = 0; bus.i_read = 0;

    // Address stability: d_addr moves during cycle 2 of a d-read.
    c0 = cyc;
    bus.d_read = 1; bus.d_addr = 16'h0040;
    push(1, 0, 16'h0040, line_of(16'h0040), c0 + LAT + 1);
    serve("stable", c0 + 2, 16'h0080);
    bus.d_read = 0;

    // Reset during cycle 2 of a d-write.
    bus.d_write = 1; bus.d_addr = 16'h0055; bus.d_wdata = 64'h0123_4567_89AB_CDEF;
    step();
    chk("rstmid_write_on", 64'(bus.mem_write), 64'd1);
    step();
    reset = 1;
    step();
    mdl_d_rdata = '0; mdl_i_rdata = '0;
    chk("rstmid_strobes", 64'({bus.mem_read, bus.mem_write}), 64'd0);
    chk("rstmid_readys", 64'({bus.d_ready, bus.i_ready}), 64'd0);
    chk("rstmid_state", 64'(dut.state_reg), 64'd0);
    reset = 0;
    bus.d_write = 0;
    bus.i_read = 1; bus.i_addr = 16'h0066;
    c0 = cyc;
    push(0, 0, 16'h0064, line_of(16'h0064), c0 + LAT + 1);
    serve("after_rst", -1, 16'h0);
    bus.i_read = 0;

    // LATENCY=1 instance: a single strobe cycle, ready in cycle 2.
    bus1.i_read = 1; bus1.i_addr = 16'h0123;
    step();
    chk("lat1_strobe", 64'(bus1.mem_read), 64'd1);
    chk("lat1_addr", 64'(bus1.mem_addr), 64'h0120);
    chk("lat1_ready_early", 64'(bus1.i_ready), 64'd0);
    step();
    chk("lat1_strobe_off", 64'(bus1.mem_read), 64'd0);
    chk("lat1_ready", 64'(bus1.i_ready), 64'd1);
    chk("lat1_rdata", bus1.i_rdata, line_of(16'h0120));
    bus1.i_read = 0;
    step();
    chk("lat1_ready_end", 64'(bus1.i_ready), 64'd0);
    $display("xfer lat1 done at cycle %0d", cyc);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
